ram_stream_reader: RTL
======================

Name: ram_stream_reader

Overview:
- Reader-side engine for the 512x8 block-RAM wrapper: fetches a run of consecutive bytes and presents them on a valid/ready byte stream.
- Sits between a RAM instance (driving its RADDR/RE/RCLKE, consuming its RDATA) and a byte consumer such as a video fetch, a UART transmitter or a CPU-side port.
- Hides the RAM's one-cycle registered read latency behind a 2-entry skid buffer, so throughput is one byte per clock while the consumer keeps m_ready high.

Parameters:
- ADDR_W, 9, RAM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, byte width.
- LEN_W, 10, length field width; must hold 2^ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  begin a transfer; sampled only in IDLE.
- base_addr  in  ADDR_W  first address; captured when start is accepted.
- length  in  LEN_W  byte count, 0..512; captured when start is accepted.
- abort  in  1  synchronous cancel of the current transfer.
- busy  out  1  high from the start-accepting edge until the transfer ends.
- done  out  1  one-cycle pulse when the last byte has been accepted (or after a zero-length start).
- ram_raddr  out  ADDR_W  RAM read address, registered.
- ram_re  out  1  RAM read enable; also drives RCLKE.
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after a ram_re edge.
- m_data  out  DATA_W  stream data, registered.
- m_valid  out  1  stream valid.
- m_ready  in  1  consumer ready; a byte transfers on an edge where m_valid and m_ready are both high.

Behaviour:
- Reset values: busy=0, done=0, ram_re=0, ram_raddr=0, m_valid=0, m_data=0, state=IDLE, FIFO empty, in-flight flag clear, remaining counts 0. Reset takes effect immediately, including mid-transfer.
- States: IDLE, RUN, FLUSH.
- IDLE, start=1, length≠0: capture base_addr and length, go to RUN, busy=1.
- IDLE, start=1, length=0: stay in IDLE; done pulses the next cycle; busy stays 0; no RAM access.
- start is ignored outside IDLE.
- RUN: issue a read (ram_re=1 at ram_raddr) when issue_left≠0 and (fifo_count + inflight − pop) < 2, where pop = m_valid & m_ready.
  - Each issue: ram_raddr increments modulo 512 (0x1FF→0x000), issue_left decrements, inflight sets for one cycle.
  - When issue_left reaches 0, go to FLUSH.
- Data capture: on the edge after an issue, ram_rdata is pushed into the FIFO. The FIFO head drives m_data/m_valid.
- Latency: after the edge that accepts start, ram_re is high for the next cycle. m_valid rises after the second edge following acceptance.
- FLUSH: wait until inflight=0 and the FIFO is empty. Then return to IDLE, busy→0, and pulse done for one cycle.
- Throughput: one byte per clock while m_ready=1. m_data must not change while m_valid=1 and m_ready=0.
- Overflow: the FIFO never overflows. The issue rule covers simultaneous push and pop.
- abort in RUN or FLUSH:
  - discard the FIFO and the in-flight read;
  - m_valid=0 and ram_re=0 from the next cycle;
  - return to IDLE with busy=0 and no done pulse.
  - abort in IDLE has no effect.
- If start and abort are both high in IDLE, start wins.
- ram_re is low in IDLE and FLUSH.

Test Plan:
1. RAM preloaded with 0x00..0xFF at addresses 0..255; start with base=0x010, length=4, m_ready=1 -> m_data 0x10,0x11,0x12,0x13 on consecutive cycles, m_valid first high 2 edges after start is accepted, one done pulse after the last byte, busy then low.
2. base=0x1FE, length=4, RAM[0x1FE..0x001]=A1,A2,A3,A4 -> stream A1,A2,A3,A4; ram_raddr wraps 0x1FF→0x000.
3. length=8, m_ready toggled randomly, then held low for 5 cycles -> m_data held stable while stalled, the 8 bytes arrive in order with no loss or duplicates, ram_re never issues past 2 outstanding bytes.
4. length=0 -> done pulse the cycle after start, busy stays 0, ram_re never high, m_valid never high.
5. length=512 with m_ready=1 -> 512 bytes in 512 consecutive cycles after the first, done pulses once.
6. abort at byte 3 of 10, and separately resetn pulsed low mid-transfer -> m_valid=0 and busy=0 immediately after, no done pulse; a new start afterwards behaves like scenario 1.

Source files
------------

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: streams a run of consecutive bytes out of a 512x8
// block RAM onto a valid/ready byte interface at one byte per clock.
module ram_stream_reader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic              infl_q, infl_d;
  logic              done_q, done_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;

  logic       pop;
  logic       push;
  logic       kill;
  logic       issue;
  logic [2:0] occ;

  // Handshake, occupancy and the read-issue rule.
  always_comb begin
    pop   = (cnt_q != 2'd0) & m_ready;
    push  = infl_q;
    kill  = abort & (state_q != S_IDLE);
    // Slots that will be held after this edge if nothing new is issued;
    // pop implies cnt_q >= 1, so this never underflows.
    occ   = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
    issue = (state_q == S_RUN) & (left_q != '0) & (occ < 3'd2);
  end

  // Transfer sequencing: start capture, address/count walk, drain, done.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    infl_d  = issue;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
            addr_d  = base_addr;
            left_d  = length;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          addr_d = addr_q + ADDR_W'(1);
          left_d = left_q - LEN_W'(1);
          if (left_q == LEN_W'(1)) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // Finish on the edge that accepts the final byte.
        if (!infl_q &&
            (cnt_q == 2'd0 ||
             (cnt_q == 2'd1 && pop))) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (kill) begin
      state_d = S_IDLE;
      left_d  = '0;
      infl_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Two-entry skid buffer; head entry is the registered stream output.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push && pop) begin
      if (cnt_q == 2'd2) begin
        head_d = tail_q;
        tail_d = ram_rdata;
      end else begin
        head_d = ram_rdata;
      end
    end else if (push) begin
      if (cnt_q == 2'd0) begin
        head_d = ram_rdata;
      end else begin
        tail_d = ram_rdata;
      end
      cnt_d = cnt_q + 2'd1;
    end else if (pop) begin
      head_d = tail_q;
      cnt_d  = cnt_q - 2'd1;
    end
    if (kill) begin
      cnt_d = 2'd0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      infl_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      infl_q  <= infl_d;
      done_q  <= done_d;
    end
  end

  // Skid buffer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign ram_raddr = addr_q;
  assign ram_re    = issue;
  assign m_data    = head_q;
  assign m_valid   = (cnt_q != 2'd0);

endmodule
